// File: rtl/fifo_wr_stage.sv
// Write-side front end of the async FIFO: valid/ready input, two-entry skid buffer, guarded winc/wdata.
// Latency: a beat accepted at edge k with the output register empty is presented on winc/wdata in cycle k+1.
// Backpressure: winc held off while wfull or the decoded pointers show full; s_ready drops once the skid entry is occupied.
//
// Ports:
//   wclk, wrst              write clock, asynchronous active-high reset
//   s_valid/s_ready/s_data  producer stream (s_ready is registered)
//   winc, wdata             FIFO write strobe and write data
//   wfull, wptr, ws_rptr    full flag, Gray write pointer, synchronized Gray read pointer
//   wlevel, walmost_full    registered fill level and almost-full flag
//   wr_count                count of FIFO writes, wraps modulo 2^32
module fifo_wr_stage #(
   parameter int ASIZE = 4,
   parameter int DSIZE = 8,
   parameter int AFULL = 12
) (
   input  logic             wclk,
   input  logic             wrst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [DSIZE-1:0] s_data,
   output logic             winc,
   output logic [DSIZE-1:0] wdata,
   input  logic             wfull,
   input  logic [ASIZE:0]   wptr,
   input  logic [ASIZE:0]   ws_rptr,
   output logic [ASIZE:0]   wlevel,
   output logic             walmost_full,
   output logic [31:0]      wr_count
);

   localparam logic [ASIZE:0] DEPTH_L = {1'b1, {ASIZE{1'b0}}};
   localparam logic [ASIZE:0] AFULL_L = (ASIZE+1)'(AFULL);

   logic [ASIZE:0]   wbin;
   logic [ASIZE:0]   rbin;
   logic [ASIZE:0]   lvl_now;
   logic             full_now;
   logic             stall;
   logic             acc;

   logic             out_valid;
   logic [DSIZE-1:0] out_data;
   logic             skid_valid;
   logic [DSIZE-1:0] skid_data;

   logic             out_valid_nxt;
   logic [DSIZE-1:0] out_data_nxt;
   logic             skid_valid_nxt;
   logic [DSIZE-1:0] skid_data_nxt;

   // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
   always_comb begin
      wbin = '0;
      rbin = '0;
      for (int i = 0; i <= ASIZE; i++) begin
         wbin[i] = ^(wptr >> i);
         rbin[i] = ^(ws_rptr >> i);
      end
   end

   // Modular subtraction at ASIZE+1 bits handles pointer wrap.
   assign lvl_now  = wbin - rbin;
   assign full_now = (lvl_now == DEPTH_L);

   // full_now covers the cycle where the pointer already shows full but the
   // registered wfull has not caught up yet.
   assign stall = wfull | full_now;
   assign winc  = out_valid & ~stall;
   assign wdata = out_data;
   assign acc   = s_valid & s_ready;

   always_comb begin
      out_valid_nxt  = out_valid;
      out_data_nxt   = out_data;
      skid_valid_nxt = skid_valid;
      skid_data_nxt  = skid_data;
      if (!out_valid || winc) begin
         if (skid_valid) begin
            // Skid holds the older beat; s_ready is low so no new beat can arrive.
            out_valid_nxt  = 1'b1;
            out_data_nxt   = skid_data;
            skid_valid_nxt = 1'b0;
         end else if (acc) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = s_data;
         end else begin
            out_valid_nxt = 1'b0;
         end
      end else if (acc) begin
         skid_valid_nxt = 1'b1;
         skid_data_nxt  = s_data;
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         skid_valid   <= 1'b0;
         skid_data    <= '0;
         s_ready      <= 1'b1;
         wlevel       <= '0;
         walmost_full <= 1'b0;
         wr_count     <= '0;
      end else begin
         out_valid    <= out_valid_nxt;
         out_data     <= out_data_nxt;
         skid_valid   <= skid_valid_nxt;
         skid_data    <= skid_data_nxt;
         // Registered from the next skid state so s_ready is low in the very
         // cycle the skid entry becomes occupied.
         s_ready      <= ~skid_valid_nxt;
         wlevel       <= lvl_now;
         walmost_full <= (lvl_now >= AFULL_L);
         wr_count     <= wr_count + {31'd0, winc};
      end
   end

endmodule

// File: tb/tb_fifo_wr_stage.sv
// Directed bench for fifo_wr_stage with a behavioural pointer stage (wfull lags the pointers by one cycle).
// Latency: checks first-beat latency, stall timing, resume, wrap and overflow guard.
// Backpressure: s_valid toggling near full and a frozen read pointer.
module tb_fifo_wr_stage;

   logic        wclk = 1'b0;
   logic        wrst;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        winc;
   logic [7:0]  wdata;
   logic        wfull;
   logic [4:0]  wptr;
   logic [4:0]  ws_rptr;
   logic [4:0]  wlevel;
   logic        walmost_full;
   logic [31:0] wr_count;

   int checks   = 0;
   int failures = 0;

   int wbin = 0;
   int rbin = 0;
   bit force_nf = 1'b0;
   logic [7:0] wq[$];
   logic [7:0] aq[$];

   fifo_wr_stage #(.ASIZE(4), .DSIZE(8), .AFULL(12)) dut (
      .wclk(wclk), .wrst(wrst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .winc(winc), .wdata(wdata),
      .wfull(wfull), .wptr(wptr), .ws_rptr(ws_rptr),
      .wlevel(wlevel), .walmost_full(walmost_full), .wr_count(wr_count)
   );

   always #5 wclk = ~wclk;

   function automatic logic [4:0] gray(input int b);
      logic [4:0] v;
      v = 5'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_ptrs();
      wptr    = gray(wbin);
      ws_rptr = gray(rbin);
   endtask

   task automatic model_reset();
      wbin = 0;
      rbin = 0;
      wfull = 1'b0;
      force_nf = 1'b0;
      wq.delete();
      aq.delete();
      drive_ptrs();
   endtask

   // One clock: sample pre-edge handshakes, then update the pointer model just after the edge.
   task automatic step(input bit do_read, output bit fired, output int lvl_old);
      bit a;
      logic [7:0] dw, da;
      #1;
      fired = winc;
      dw = wdata;
      a = s_valid & s_ready;
      da = s_data;
      lvl_old = (wbin - rbin) & 31;
      @(posedge wclk);
      #1;
      chk("no_overflow", {31'd0, fired && (lvl_old == 16)}, 32'd0);
      if (fired) begin
         wq.push_back(dw);
         wbin = (wbin + 1) % 32;
      end
      if (a) aq.push_back(da);
      if (do_read && lvl_old > 0) rbin = (rbin + 1) % 32;
      wfull = force_nf ? 1'b0 : (lvl_old == 16);
      drive_ptrs();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit f;
      int lv;
      int guard;

      // Reset state
      wrst = 1'b1;
      s_valid = 1'b0;
      s_data = 8'h00;
      model_reset();
      #1;
      chk("rst_winc", {31'd0, winc}, 32'd0);
      chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
      chk("rst_wlevel", {27'd0, wlevel}, 32'd0);
      chk("rst_almost", {31'd0, walmost_full}, 32'd0);
      chk("rst_wr_count", wr_count, 32'd0);
      chk("rst_wdata", {24'd0, wdata}, 32'd0);
      @(negedge wclk);
      @(negedge wclk);
      wrst = 1'b0;

      // Streaming 20 beats, read pointer frozen at 0
      for (int i = 0; i < 24; i++) begin
         s_valid = (aq.size() < 20);
         s_data  = 8'(aq.size());
         step(1'b0, f, lv);
         if (i == 0) begin
            chk("lat_winc", {31'd0, winc}, 32'd1);
            chk("lat_wdata", {24'd0, wdata}, 32'd0);
         end
         chk("str_wlevel", {27'd0, wlevel}, 32'(lv));
         chk("str_almost", {31'd0, walmost_full}, {31'd0, lv >= 12});
         if (f && wq.size() == 16) begin
            chk("guard_winc", {31'd0, winc}, 32'd0);
            chk("guard_wfull_lag", {31'd0, wfull}, 32'd0);
         end
      end
      chk("str_writes", 32'(wq.size()), 32'd16);
      for (int i = 0; i < 16; i++) chk("str_order", {24'd0, wq[i]}, 32'(i));
      chk("str_accepted", 32'(aq.size()), 32'd18);
      chk("str_wr_count", wr_count, 32'd16);
      chk("str_s_ready", {31'd0, s_ready}, 32'd0);
      chk("str_winc", {31'd0, winc}, 32'd0);
      chk("str_wfull", {31'd0, wfull}, 32'd1);
      chk("str_wlevel_full", {27'd0, wlevel}, 32'd16);
      chk("str_almost_full", {31'd0, walmost_full}, 32'd1);

      // Resume: reader frees 3 entries
      rbin = (rbin + 3) % 32;
      drive_ptrs();
      for (int i = 0; i < 6; i++) begin
         s_valid = (aq.size() < 20);
         s_data  = 8'(aq.size());
         step(1'b0, f, lv);
      end
      chk("res_writes", 32'(wq.size()), 32'd19);
      chk("res_d16", {24'd0, wq[16]}, 32'h10);
      chk("res_d17", {24'd0, wq[17]}, 32'h11);
      chk("res_d18", {24'd0, wq[18]}, 32'h12);
      chk("res_wr_count", wr_count, 32'd19);
      chk("res_winc", {31'd0, winc}, 32'd0);
      chk("res_s_ready", {31'd0, s_ready}, 32'd1);

      // Fill the skid entry, then reset asynchronously with both registers full
      s_valid = 1'b1;
      s_data  = 8'h14;
      step(1'b0, f, lv);
      step(1'b0, f, lv);
      chk("pre_rst_s_ready", {31'd0, s_ready}, 32'd0);
      #2;
      wrst = 1'b1;
      #1;
      chk("arst_winc", {31'd0, winc}, 32'd0);
      chk("arst_s_ready", {31'd0, s_ready}, 32'd1);
      chk("arst_wlevel", {27'd0, wlevel}, 32'd0);
      chk("arst_wr_count", wr_count, 32'd0);
      chk("arst_almost", {31'd0, walmost_full}, 32'd0);
      s_valid = 1'b0;
      model_reset();
      @(negedge wclk);
      wrst = 1'b0;

      // Backpressure bubbles near full
      for (int i = 0; i < 60; i++) begin
         s_valid = i[0];
         s_data  = 8'(8'h40 + aq.size());
         step((i >= 30) && (i % 3 == 0), f, lv);
      end
      s_valid = 1'b0;
      for (int i = 0; i < 25; i++) step(1'b1, f, lv);
      chk("bp_count", 32'(wq.size()), 32'(aq.size()));
      for (int i = 0; i < wq.size() && i < aq.size(); i++)
         chk("bp_order", {24'd0, wq[i]}, {24'd0, aq[i]});
      chk("bp_wr_count", wr_count, 32'(wq.size()));
      chk("bp_wlevel", {27'd0, wlevel}, 32'd0);

      // Wrap: 100 beats with a reader taking one per cycle
      wrst = 1'b1;
      model_reset();
      #1;
      @(negedge wclk);
      wrst = 1'b0;
      guard = 0;
      while (wq.size() < 100 && guard < 400) begin
         s_valid = (aq.size() < 100);
         s_data  = 8'(aq.size());
         step(1'b1, f, lv);
         chk("wrap_wlevel_le2", {31'd0, wlevel <= 5'd2}, 32'd1);
         guard++;
      end
      s_valid = 1'b0;
      chk("wrap_wr_count", wr_count, 32'd100);
      for (int i = 0; i < 100 && i < wq.size(); i++)
         chk("wrap_order", {24'd0, wq[i]}, 32'(i));

      // Overflow guard: pointers encode full while wfull is held low
      force_nf = 1'b1;
      wfull = 1'b0;
      wbin = (rbin + 16) % 32;
      drive_ptrs();
      s_valid = 1'b1;
      s_data  = 8'hA5;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, f, lv);
         chk("ovf_winc", {31'd0, winc}, 32'd0);
      end
      chk("ovf_wr_count", wr_count, 32'd100);
      chk("ovf_wlevel", {27'd0, wlevel}, 32'd16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
